lsu_ctrl: RTL and testbench



---
 rtl/lsu_ctrl.sv | 124 ++++++++++++
 tb/tb_lsu_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer to a handshaked data bus (optional bus timeout with LSU_TIMEOUT_EN)
module lsu_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [2:0]        mem_acc_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              done,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic we_q, we_d;
  logic [2:0] mode_q, mode_d;
  logic [1:0] off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0] be_q, be_d;
  logic [31:0] wdata_q, wdata_d, load_q, load_d, lane, ext;
  logic is_half, is_word, acc, mis, tmo;
  assign is_half = mem_acc_mode == 3'd1 || mem_acc_mode == 3'd4;
  assign is_word = mem_acc_mode == 3'd2;
  assign acc = (rd_en | wr_en) & (mem_acc_mode < 3'd5);
  assign mis = (is_half & addr[0]) | (is_word & (|addr[1:0]));
  assign lane = bus_rdata >> {off_q, 3'b000};
  assign ext = mode_q == 3'd0 ? {{24{lane[7]}}, lane[7:0]}
             : mode_q == 3'd3 ? {24'd0, lane[7:0]}
             : mode_q == 3'd1 ? {{16{lane[15]}}, lane[15:0]}
             : mode_q == 3'd4 ? {16'd0, lane[15:0]}
             : lane;
`ifdef LSU_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (state_q == REQ || state_q == WAIT) ? cnt_q + 1'b1 : '0;
  assign tmo = cnt_q == CW'(TIMEOUT_CYC - 1);
  assign bus_err = state_q == ERR;
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYC);
  assign tmo = 1'b0;
  assign bus_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    mode_d = mode_q;
    off_d = off_q;
    addr_d = addr_q;
    be_d = be_q;
    wdata_d = wdata_q;
    load_d = load_q;
    stall = 1'b0;
    misalign_err = 1'b0;
    case (state_q)
      IDLE: begin
        misalign_err = acc & mis;
        stall = acc & ~mis;
        if (acc && !mis) begin
          state_d = REQ;
          we_d = wr_en;
          mode_d = mem_acc_mode;
          off_d = addr[1:0];
          addr_d = {addr[ADDR_W-1:2], 2'b00};
          be_d = is_word ? 4'hf : is_half ? (addr[1] ? 4'hc : 4'h3) : 4'b0001 << addr[1:0];
          wdata_d = is_word ? wdata : is_half ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        end
      end
      REQ: begin
        stall = 1'b1;
        state_d = bus_gnt ? (we_q ? DONE : WAIT) : tmo ? ERR : REQ;
      end
      WAIT: begin
        stall = 1'b1;
        state_d = bus_rvalid ? DONE : tmo ? ERR : WAIT;
        load_d = bus_rvalid ? ext : load_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      mode_q <= '0;
      off_q <= '0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      load_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      mode_q <= mode_d;
      off_q <= off_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      load_q <= load_d;
    end
  end
  assign bus_req = state_q == REQ;
  assign bus_we = we_q;
  assign bus_addr = addr_q;
  assign bus_be = be_q;
  assign bus_wdata = wdata_q;
  assign load_data = load_q;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized self-checking bench for lsu_ctrl against a transaction-level model
module tb_lsu_ctrl;
`ifdef LSU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  localparam int MAXD = (TO >= 8) ? 3 : 1;
  logic clk = 0, rst_n = 0, rd_en = 0, wr_en = 0, bus_gnt = 0, bus_rvalid = 0;
  logic [2:0] mem_acc_mode = 0;
  logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
  logic stall, done, misalign_err, bus_err, bus_req, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  int n_chk = 0, n_err = 0;
  logic [31:0] model_load = 0;
  always #5 clk = ~clk;
  lsu_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .mem_acc_mode(mem_acc_mode),
    .addr(addr), .wdata(wdata), .stall(stall), .load_data(load_data), .done(done),
    .misalign_err(misalign_err), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int size_of(input logic [2:0] m);
    return (m == 3'd2) ? 4 : (m == 3'd1 || m == 3'd4) ? 2 : 1;
  endfunction
  function automatic logic [31:0] model_be(input logic [2:0] m, input logic [31:0] a);
    logic [31:0] ones;
    ones = (32'd1 << size_of(m)) - 32'd1;
    return ones << (a % 4);
  endfunction
  function automatic logic [31:0] model_wd(input logic [2:0] m, input logic [31:0] wd);
    int sz;
    sz = size_of(m);
    if (sz == 1) return (wd & 32'hff) * 32'h0101_0101;
    if (sz == 2) return (wd & 32'hffff) * 32'h0001_0001;
    return wd;
  endfunction
  function automatic logic [31:0] model_ld(input logic [2:0] m, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] s, v, span;
    int sz;
    sz = size_of(m);
    s = rd >> (8 * (a % 4));
    if (sz == 4) return s;
    span = 32'd1 << (8 * sz);
    v = s % span;
    if ((m == 3'd0 || m == 3'd1) && v >= span / 2) v = v - span;
    return v;
  endfunction
  task automatic access(input logic w, input logic r, input logic [2:0] m, input logic [31:0] a,
                        input logic [31:0] wd, input int gd, input int rdl, input logic [31:0] rd);
    int sz, cyc, reqs, stalls, wt;
    bit acc, mis, seen_req, got_done;
    sz = size_of(m);
    acc = (w || r) && (m < 3'd5);
    mis = acc && ((a % sz) != 0);
    @(negedge clk);
    wr_en = w; rd_en = r; mem_acc_mode = m; addr = a; wdata = wd; bus_gnt = 0; bus_rvalid = 0;
    #1;
    chk("misalign_err", 32'(misalign_err), 32'(acc && mis));
    chk("stall_first", 32'(stall), 32'(acc && !mis));
    chk("req_first", 32'(bus_req), 0);
    if (!acc || mis) begin
      @(negedge clk);
      wr_en = 0; rd_en = 0;
      #1;
      chk("idle_req", 32'(bus_req), 0);
      chk("idle_stall", 32'(stall), 0);
      chk("idle_done", 32'(done), 0);
      chk("idle_load_kept", load_data, model_load);
      return;
    end
    if (!w) model_load = model_ld(m, a, rd);
    stalls = 1; reqs = 0; wt = 0; cyc = 0; seen_req = 0; got_done = 0;
    while (!got_done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      bus_gnt = 0; bus_rvalid = 0; bus_rdata = $urandom;
      if (done) begin
        got_done = 1;
        chk("done_stall", 32'(stall), 0);
        chk("done_req", 32'(bus_req), 0);
        chk("done_bus_err", 32'(bus_err), 0);
        chk("load_data", load_data, model_load);
      end else if (bus_req) begin
        if (!seen_req) begin
          chk("bus_addr", bus_addr, a & 32'hffff_fffc);
          chk("bus_be", 32'(bus_be), model_be(m, a));
          chk("bus_we", 32'(bus_we), 32'(w));
          if (w) chk("bus_wdata", bus_wdata, model_wd(m, wd));
        end
        seen_req = 1;
        bus_gnt = (reqs == gd);
        bus_rvalid = 1'($urandom_range(0, 1));
        reqs++;
      end else if (seen_req) begin
        bus_rvalid = (wt == rdl);
        if (bus_rvalid) bus_rdata = rd;
        wt++;
      end
      #1;
      if (!got_done && stall) stalls++;
    end
    chk("done_seen", 32'(got_done), 1);
    chk("stall_cycles", 32'(stalls), w ? 32'(gd + 2) : 32'(gd + rdl + 3));
    chk("req_cycles", 32'(reqs), 32'(gd + 1));
    @(negedge clk);
    wr_en = 0; rd_en = 0; bus_gnt = 0; bus_rvalid = 0;
    #1;
    chk("done_pulse_end", 32'(done), 0);
    chk("load_hold", load_data, model_load);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic w, r;
    logic [2:0] m;
    logic [31:0] a;
    int reqs;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_req", 32'(bus_req), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_load", load_data, 0);
    chk("rst_be", 32'(bus_be), 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_we", 32'(bus_we), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    @(negedge clk);
    rst_n = 1;
    access(1, 0, 3'd2, 32'h104, 32'hDEAD_BEEF, 0, 0, 0);
    access(0, 1, 3'd0, 32'h203, 0, 0, 0, 32'h8011_2233);
    chk("lb_signed", load_data, 32'hFFFF_FF80);
    access(0, 1, 3'd3, 32'h203, 0, 0, 0, 32'h8011_2233);
    chk("lbu", load_data, 32'h0000_0080);
    access(1, 0, 3'd1, 32'h12, 32'h0000_ABCD, 0, 0, 0);
    access(0, 1, 3'd4, 32'h12, 0, 0, 0, 32'hABCD_0000);
    chk("lhu", load_data, 32'h0000_ABCD);
    access(0, 1, 3'd2, 32'h6, 0, 0, 0, 0);
    access(1, 1, 3'd2, 32'h20, 32'h1234_5678, MAXD, 0, 0);
`ifndef LSU_TIMEOUT_EN
    access(1, 0, 3'd2, 32'h300, 32'hCAFE_F00D, 5, 0, 0);
`endif
    @(negedge clk);
    rd_en = 1; mem_acc_mode = 3'd2; addr = 32'h40;
    @(negedge clk);
    #1;
    chk("rst_mid_req", 32'(bus_req), 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; rd_en = 0;
    #1;
    chk("rst_mid_req_after", 32'(bus_req), 0);
    chk("rst_mid_stall", 32'(stall), 0);
    chk("rst_mid_load", load_data, 0);
    model_load = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_mid_no_done", 32'(done), 0);
      chk("rst_mid_idle_req", 32'(bus_req), 0);
    end
`ifdef LSU_TIMEOUT_EN
    @(negedge clk);
    wr_en = 1; mem_acc_mode = 3'd2; addr = 32'h80;
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (bus_req) reqs++;
      if (bus_err) begin
        chk("tmo_stall", 32'(stall), 0);
        chk("tmo_req", 32'(bus_req), 0);
        wr_en = 0;
        break;
      end
    end
    chk("tmo_err_seen", 32'(bus_err), 1);
    chk("tmo_req_cycles", 32'(reqs), 32'(TO));
    @(negedge clk);
    #1;
    chk("tmo_err_pulse", 32'(bus_err), 0);
    chk("tmo_idle_stall", 32'(stall), 0);
    chk("tmo_idle_req", 32'(bus_req), 0);
    access(1, 0, 3'd2, 32'h84, 32'h5555_AAAA, TO - 1, 0, 0);
`endif
    repeat (200) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      m = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ((m == 3'd2) ? 32'hffff_fffc : (m == 3'd1 || m == 3'd4) ? 32'hffff_fffe : 32'hffff_ffff);
      access(w, r, m, a, $urandom, $urandom_range(0, MAXD), $urandom_range(0, MAXD), $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
